// File: rtl/mips_reg.sv
// mips_reg: 32 x 32-bit MIPS general-purpose register file.
// Two combinational read ports, one synchronous write port, r0 reads as zero.
// Reset is asynchronous and active-low; it clears every register.
module mips_reg (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [4:0]  R_Addr_A,
   input  logic [4:0]  R_Addr_B,
   input  logic [4:0]  W_Addr,
   input  logic [31:0] W_Data,
   input  logic        Write_Reg,
   output logic [31:0] R_Data_A,
   output logic [31:0] R_Data_B
);

   localparam int NUM_REGS = 32;

   logic [NUM_REGS-1:0][31:0] regs;
   logic                      wr_en;

   // r0 is never written, so it holds the reset value of zero permanently
   assign wr_en = Write_Reg && (W_Addr != 5'd0);

   // Register storage: async clear, write on rising edge when enabled
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         regs <= '0;
      end else if (wr_en) begin
         regs[W_Addr] <= W_Data;
      end
   end

   // Read ports: purely combinational, no bypass from the write port
   always_comb begin
      R_Data_A = (R_Addr_A == 5'd0) ? 32'h0 : regs[R_Addr_A];
      R_Data_B = (R_Addr_B == 5'd0) ? 32'h0 : regs[R_Addr_B];
   end

endmodule

// File: tb/tb_mips_reg.sv
// tb_mips_reg: directed self-checking bench for the mips_reg register file.
module tb_mips_reg;

   logic        Clk;
   logic        Reset;
   logic [4:0]  R_Addr_A;
   logic [4:0]  R_Addr_B;
   logic [4:0]  W_Addr;
   logic [31:0] W_Data;
   logic        Write_Reg;
   logic [31:0] R_Data_A;
   logic [31:0] R_Data_B;

   int checks   = 0;
   int failures = 0;

   mips_reg dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .R_Addr_A  (R_Addr_A),
      .R_Addr_B  (R_Addr_B),
      .W_Addr    (W_Addr),
      .W_Data    (W_Data),
      .Write_Reg (Write_Reg),
      .R_Data_A  (R_Data_A),
      .R_Data_B  (R_Data_B)
   );

   // Free-running clock, first rising edge at t=5
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One-edge write: drive on falling edge, capture on the next rising edge
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge Clk);
      W_Addr    = a;
      W_Data    = d;
      Write_Reg = 1'b1;
      @(posedge Clk);
      #1 Write_Reg = 1'b0;
   endtask

   // Set both read addresses, let them settle, compare both ports
   task automatic rd(input string tag, input logic [4:0] aa, input logic [4:0] ab,
                     input logic [31:0] ea, input logic [31:0] eb);
      R_Addr_A = aa;
      R_Addr_B = ab;
      #1;
      chk({tag, "_A"}, R_Data_A, ea);
      chk({tag, "_B"}, R_Data_B, eb);
   endtask

   // Directed sequence
   initial begin
      Reset     = 1'b0;
      R_Addr_A  = 5'd0;
      R_Addr_B  = 5'd0;
      W_Addr    = 5'd0;
      W_Data    = 32'h0;
      Write_Reg = 1'b0;

      // Reset held, no clock edge yet (first edge at t=5)
      #1;
      rd("rst_r1", 5'd1, 5'd1, 32'h0, 32'h0);
      rd("rst_r31", 5'd31, 5'd31, 32'h0, 32'h0);

      // Write attempted while reset is low must be lost
      W_Addr = 5'd7; W_Data = 32'hCAFE_F00D; Write_Reg = 1'b1;
      @(posedge Clk); #1;
      Write_Reg = 1'b0;
      rd("rst_wr_r7", 5'd7, 5'd7, 32'h0, 32'h0);

      // Release reset between edges
      @(negedge Clk);
      Reset = 1'b1;

      // Basic write/read
      wr(5'd1, 32'h1111_1111);
      wr(5'd2, 32'h2222_2222);
      rd("basic", 5'd1, 5'd2, 32'h1111_1111, 32'h2222_2222);

      // Write to r0 is discarded
      wr(5'd0, 32'hFFFF_FFFF);
      rd("zero", 5'd0, 5'd0, 32'h0, 32'h0);

      // Enable gating
      wr(5'd5, 32'hA5A5_A5A5);
      @(negedge Clk);
      W_Addr = 5'd5; W_Data = 32'h1234_5678; Write_Reg = 1'b0;
      @(posedge Clk); #1;
      rd("gate_r5", 5'd5, 5'd5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

      // Both ports on the same and on distinct registers, r31 boundary
      wr(5'd31, 32'hDEAD_BEEF);
      rd("r31_r5", 5'd31, 5'd5, 32'hDEAD_BEEF, 32'hA5A5_A5A5);
      rd("r2_r0", 5'd2, 5'd0, 32'h2222_2222, 32'h0);

      // No bypass: old value before the edge, new value after it
      wr(5'd3, 32'h0000_0003);
      @(negedge Clk);
      R_Addr_A = 5'd3; R_Addr_B = 5'd1;
      W_Addr = 5'd3; W_Data = 32'h0000_0033; Write_Reg = 1'b1;
      #1;
      chk("nobyp_pre", R_Data_A, 32'h0000_0003);
      @(posedge Clk); #1;
      Write_Reg = 1'b0;
      chk("nobyp_post", R_Data_A, 32'h0000_0033);
      chk("nobyp_other", R_Data_B, 32'h1111_1111);

      // Overwrite of a loaded register
      wr(5'd1, 32'h0BAD_CAFE);
      rd("overwrite", 5'd1, 5'd31, 32'h0BAD_CAFE, 32'hDEAD_BEEF);

      // Async reset mid-operation: drop between edges, outputs clear at once
      wr(5'd1, 32'h1111_1111);
      rd("pre_rst", 5'd1, 5'd31, 32'h1111_1111, 32'hDEAD_BEEF);
      @(negedge Clk);
      #2 Reset = 1'b0;
      #1;
      chk("async_rst_A", R_Data_A, 32'h0);
      chk("async_rst_B", R_Data_B, 32'h0);
      #1 Reset = 1'b1;
      @(posedge Clk); #1;
      rd("post_rst", 5'd1, 5'd31, 32'h0, 32'h0);
      rd("post_rst2", 5'd5, 5'd3, 32'h0, 32'h0);

      // First write after reset release lands on the next edge
      wr(5'd9, 32'h0000_0009);
      rd("after_rst_wr", 5'd9, 5'd1, 32'h0000_0009, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
